cam_capture_ctrl: RTL and testbench
===================================

CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, 8, camera byte-bus width.
REQ-002 SHALL have parameter ADDR_W, 20, pixel-address width.
REQ-003 SHALL have parameter CNT_W, 12, width of x/y counters and crop ports.
REQ-004 SHALL have port clk  input  1  sole clock, camera pixel clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  input  1  capture enable, sampled at frame start.
REQ-007 SHALL have port fmt  input  1  0=RAW8 (1 byte/pixel), 1=RGB565 (2 bytes/pixel), sampled at frame start.
REQ-008 SHALL have ports csi_data, csi_vsync, csi_hsync  input  DATA_W/1/1  camera bus; vsync high = frame sync, hsync high = line valid.
REQ-009 SHALL have ports crop_x0, crop_y0, crop_w, crop_h  input  CNT_W each  crop window in pixels/lines.
REQ-010 SHALL have port pix_data  output  2*DATA_W  assembled pixel.
REQ-011 SHALL have port pix_valid  output  1  one-cycle write strobe per pixel.
REQ-012 SHALL have port pix_addr  output  ADDR_W  frame-relative pixel address.
REQ-013 SHALL have ports frame_done (output, 1, one-cycle pulse) and frame_cnt (output, 16, completed frames).
REQ-014 SHALL have port err_odd  output  1  sticky: RGB565 line ended on odd byte.

Function
REQ-015 Csi inputs SHALL be registered once; pix_valid asserts 2 clk after the pixel's final byte is at the pins.
REQ-016 FSM states: IDLE, VSYNC, ACTIVE; IDLE->VSYNC on vsync rise with enable=1; VSYNC->ACTIVE on vsync fall; ACTIVE->VSYNC (enable=1) or IDLE (enable=0) on vsync rise.
REQ-017 On ACTIVE->VSYNC/IDLE transition SHALL pulse frame_done one cycle and increment frame_cnt (mod 2^16).
REQ-018 fmt and enable SHALL latch on vsync rise; mid-frame changes ignored.
REQ-019 fmt=1: first byte is high byte, pix_data={b0,b1}; fmt=0: pix_data={zeros,b}.
REQ-020 Byte phase SHALL reset to 0 at each hsync rise; trailing odd byte at hsync fall discarded and sets err_odd.
REQ-021 x counter counts pixels within a line, clears at hsync rise; y counter increments on hsync fall in ACTIVE, clears at VSYNC entry.
REQ-022 pix_addr SHALL be 0 for first emitted pixel of a frame, +1 after each pix_valid, wrap modulo 2^ADDR_W.
REQ-023 vsync rise during hsync SHALL win: partial pixel dropped, no pix_valid, frame ends.
REQ-024 Bytes while hsync low or outside ACTIVE SHALL be ignored.
REQ-025 err_odd SHALL clear only on reset.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, pix_data=0, pix_valid=0, pix_addr=0, frame_done=0, frame_cnt=0, err_odd=0, counters=0.
REQ-027 Reset release mid-frame SHALL wait in IDLE for next vsync rise; no partial-frame output.

Configuration
REQ-028 Macro CAM_CAPTURE_CROP_EN defined: pixel emitted only if crop_x0<=x<crop_x0+crop_w and crop_y0<=y<crop_y0+crop_h; addresses stay contiguous; crop ports latched at vsync rise.
REQ-029 CAM_CAPTURE_CROP_EN undefined: crop ports ignored, every pixel emitted.

Verification
REQ-030 RGB565, 4x2 frame, bytes 0x01..0x10 -> 8 pix_valid, pix_data 0x0102..0x0F10, pix_addr 0..7, one frame_done, frame_cnt=1.
REQ-031 RAW8, line 0xAA,0xBB,0xCC -> pix_data 0x00AA,0x00BB,0x00CC, addr 0..2.
REQ-032 RGB565 line of 5 bytes -> 2 pixels, err_odd=1 until reset.
REQ-033 enable=0 at vsync rise -> zero pix_valid that frame, frame_cnt unchanged.
REQ-034 Crop macro on, 8x4 frame, window (2,1,3,2) -> 6 pixels, addr 0..5, only x=2..4, y=1..2.
REQ-035 reset_n low mid-line -> outputs zero same cycle; next full frame starts at pix_addr 0.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cam_capture_ctrl
// Brief    : Camera byte-bus capture controller. Registers the parallel
//            camera bus, tracks frame/line framing, assembles RAW8 or RGB565
//            pixels and emits one write strobe per pixel with a contiguous
//            frame-relative address.
// Ports    : clk, reset_n                 - pixel clock, async active-low reset
//            enable, fmt                   - capture enable / pixel format
//                                            (both latched at vsync rise)
//            csi_data, csi_vsync, csi_hsync- camera bus
//            crop_x0, crop_y0, crop_w, crop_h - crop window
//            pix_data, pix_valid, pix_addr - pixel write port
//            frame_done, frame_cnt         - frame completion pulse / count
//            err_odd                       - sticky odd-byte RGB565 line error
// Config   : define CAM_CAPTURE_CROP_EN to enable the crop window; when it is
//            undefined the crop ports are ignored and every pixel is emitted.
// Revision : 1.0 - initial release
// ============================================================================
module cam_capture_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 20,
    parameter int CNT_W  = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                fmt,
    input  logic [DATA_W-1:0]   csi_data,
    input  logic                csi_vsync,
    input  logic                csi_hsync,
    input  logic [CNT_W-1:0]    crop_x0,
    input  logic [CNT_W-1:0]    crop_y0,
    input  logic [CNT_W-1:0]    crop_w,
    input  logic [CNT_W-1:0]    crop_h,
    output logic [2*DATA_W-1:0] pix_data,
    output logic                pix_valid,
    output logic [ADDR_W-1:0]   pix_addr,
    output logic                frame_done,
    output logic [15:0]         frame_cnt,
    output logic                err_odd
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VSYNC  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [DATA_W-1:0]   r_data;
    logic                r_vsync;
    logic                r_vsync_d;
    logic                r_hsync;
    logic                r_hsync_d;
    logic                r_fmt;
    logic                r_phase;
    logic [DATA_W-1:0]   r_hi;
    logic [CNT_W-1:0]    r_x;
    logic [CNT_W-1:0]    r_y;
    logic [ADDR_W-1:0]   r_next_addr;

    logic                w_vs_rise;
    logic                w_vs_fall;
    logic                w_hs_rise;
    logic                w_hs_fall;
    logic                w_phase;
    logic [CNT_W-1:0]    w_x;
    logic                w_pix_done;
    logic [2*DATA_W-1:0] w_pix_word;
    logic                w_in_crop;
    logic                w_start;

    // ------------------------------------------------------------------------
    // Camera bus input register. The vsync history resets high so that a
    // reset released while vsync is already high is not mistaken for a frame
    // start: a genuine rise has to be seen low first.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= '0;
            r_vsync   <= 1'b1;
            r_vsync_d <= 1'b1;
            r_hsync   <= 1'b0;
            r_hsync_d <= 1'b0;
        end else begin
            r_data    <= csi_data;
            r_vsync   <= csi_vsync;
            r_vsync_d <= r_vsync;
            r_hsync   <= csi_hsync;
            r_hsync_d <= r_hsync;
        end
    end

    assign w_vs_rise = r_vsync & ~r_vsync_d;
    assign w_vs_fall = ~r_vsync & r_vsync_d;
    assign w_hs_rise = r_hsync & ~r_hsync_d;
    assign w_hs_fall = ~r_hsync & r_hsync_d;

    // The first byte of a line always starts a new pixel at x = 0, whatever
    // state the previous line left behind.
    assign w_phase    = w_hs_rise ? 1'b0 : r_phase;
    assign w_x        = w_hs_rise ? '0 : r_x;
    assign w_pix_done = r_hsync & (~r_fmt | w_phase);
    assign w_pix_word = r_fmt ? {r_hi, r_data} : {{DATA_W{1'b0}}, r_data};

    // A new frame is armed from IDLE or at the end of an active frame.
    assign w_start = w_vs_rise & enable & ((r_state == ST_IDLE) | (r_state == ST_ACTIVE));

`ifdef CAM_CAPTURE_CROP_EN
    logic [CNT_W-1:0] r_crop_x0;
    logic [CNT_W-1:0] r_crop_y0;
    logic [CNT_W-1:0] r_crop_w;
    logic [CNT_W-1:0] r_crop_h;
    logic [CNT_W:0]   w_x_end;
    logic [CNT_W:0]   w_y_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_crop_x0 <= '0;
            r_crop_y0 <= '0;
            r_crop_w  <= '0;
            r_crop_h  <= '0;
        end else if (w_start) begin
            r_crop_x0 <= crop_x0;
            r_crop_y0 <= crop_y0;
            r_crop_w  <= crop_w;
            r_crop_h  <= crop_h;
        end
    end

    // One extra bit so x0 + w near the counter limit does not wrap.
    assign w_x_end   = {1'b0, r_crop_x0} + {1'b0, r_crop_w};
    assign w_y_end   = {1'b0, r_crop_y0} + {1'b0, r_crop_h};
    assign w_in_crop = (w_x >= r_crop_x0) && ({1'b0, w_x} < w_x_end) &&
                       (r_y >= r_crop_y0) && ({1'b0, r_y} < w_y_end);
`else
    logic w_unused_crop;
    assign w_unused_crop = ^{crop_x0, crop_y0, crop_w, crop_h};
    assign w_in_crop     = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Framing FSM, pixel assembly and registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_fmt       <= 1'b0;
            r_phase     <= 1'b0;
            r_hi        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_next_addr <= '0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_addr    <= '0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            err_odd     <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_VSYNC;
                    end
                end

                ST_VSYNC: begin
                    if (w_vs_fall) begin
                        r_state <= ST_ACTIVE;
                        r_phase <= 1'b0;
                        r_x     <= '0;
                    end
                end

                ST_ACTIVE: begin
                    if (w_vs_rise) begin
                        // Frame end wins over any line in flight; a half
                        // assembled pixel is simply dropped.
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        r_phase    <= 1'b0;
                        r_x        <= '0;
                        r_state    <= enable ? ST_VSYNC : ST_IDLE;
                    end else if (r_hsync) begin
                        if (w_pix_done) begin
                            r_phase <= 1'b0;
                            r_x     <= w_x + C_CNT_ONE;
                            if (w_in_crop) begin
                                pix_valid   <= 1'b1;
                                pix_data    <= w_pix_word;
                                pix_addr    <= r_next_addr;
                                r_next_addr <= r_next_addr + C_ADDR_ONE;
                            end
                        end else begin
                            r_phase <= 1'b1;
                            r_hi    <= r_data;
                            r_x     <= w_x;
                        end
                    end else if (w_hs_fall) begin
                        r_y <= r_y + C_CNT_ONE;
                        // Phase 1 at line end means a lone high byte was left.
                        if (r_phase) begin
                            err_odd <= 1'b1;
                        end
                        r_phase <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_start) begin
                r_fmt       <= fmt;
                r_y         <= '0;
                r_next_addr <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_capture_ctrl
// Brief    : Self-checking bench for cam_capture_ctrl. Stimulus tasks push
//            expected pixels into a scoreboard queue; a monitor pops and
//            compares them as pix_valid strobes appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_capture_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 20;
    localparam int CNT_W  = 12;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                enable;
    logic                fmt;
    logic [DATA_W-1:0]   csi_data;
    logic                csi_vsync;
    logic                csi_hsync;
    logic [CNT_W-1:0]    crop_x0;
    logic [CNT_W-1:0]    crop_y0;
    logic [CNT_W-1:0]    crop_w;
    logic [CNT_W-1:0]    crop_h;
    logic [2*DATA_W-1:0] pix_data;
    logic                pix_valid;
    logic [ADDR_W-1:0]   pix_addr;
    logic                frame_done;
    logic [15:0]         frame_cnt;
    logic                err_odd;

    always #5 clk = ~clk;

    cam_capture_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .fmt        (fmt),
        .csi_data   (csi_data),
        .csi_vsync  (csi_vsync),
        .csi_hsync  (csi_hsync),
        .crop_x0    (crop_x0),
        .crop_y0    (crop_y0),
        .crop_w     (crop_w),
        .crop_h     (crop_h),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_addr   (pix_addr),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .err_odd    (err_odd)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [19:0] addr;
    } pix_t;

    pix_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_pix = 0;
    int   n_done = 0;

    // Reference model of the capture framing.
    bit   b_active = 0;
    bit   b_fmt    = 0;
    bit   b_err    = 0;
    int   b_addr   = 0;
    int   b_y      = 0;
    int   exp_cnt  = 0;
    int   exp_done = 0;
    int   b_cx0 = 0, b_cy0 = 0, b_cw = 0, b_ch = 0;

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        pix_t e;
        if (frame_done === 1'b1) n_done++;
        if (pix_valid === 1'b1) begin
            n_pix++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pix: got data=%h addr=%0d, required no pixel", pix_data, pix_addr);
            end else begin
                e = sb.pop_front();
                if (pix_data !== e.data || pix_addr !== e.addr) begin
                    bad++;
                    $display("FAIL pix: got data=%h addr=%0d, required data=%h addr=%0d",
                             pix_data, pix_addr, e.data, e.addr);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit in_crop(input int x, input int y);
`ifdef CAM_CAPTURE_CROP_EN
        return (x >= b_cx0) && (x < b_cx0 + b_cw) && (y >= b_cy0) && (y < b_cy0 + b_ch);
`else
        return 1'b1;
`endif
    endfunction

    task automatic push_pix(input logic [15:0] d, input int x);
        pix_t p;
        if (in_crop(x, b_y)) begin
            p.data = d;
            p.addr = 20'(b_addr);
            sb.push_back(p);
            b_addr++;
        end
    endtask

    // Frame sync pulse: ends the running frame (if any) and arms the next.
    task automatic vsync_pulse();
        csi_vsync = 1'b1;
        if (b_active) begin
            exp_cnt = (exp_cnt + 1) % 65536;
            exp_done++;
        end
        b_active = enable;
        b_fmt    = fmt;
        b_addr   = 0;
        b_y      = 0;
        b_cx0 = int'(crop_x0); b_cy0 = int'(crop_y0);
        b_cw  = int'(crop_w);  b_ch  = int'(crop_h);
        cyc(2);
        csi_vsync = 1'b0;
        cyc(2);
    endtask

    task automatic send_line(input int n, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] b;
        logic [7:0] hi;
        int         px;
        hi = 8'h00;
        px = 0;
        for (int i = 0; i < n; i++) begin
            b = 8'(int'(base) + i * int'(step));
            csi_data  = b;
            csi_hsync = 1'b1;
            if (b_active) begin
                if (!b_fmt) begin
                    push_pix({8'h00, b}, px);
                    px++;
                end else if ((i % 2) == 0) begin
                    hi = b;
                end else begin
                    push_pix({hi, b}, px);
                    px++;
                end
            end
            cyc(1);
        end
        csi_hsync = 1'b0;
        csi_data  = 8'h00;
        if (b_active) begin
            if (b_fmt && (n % 2) == 1) b_err = 1'b1;
            b_y++;
        end
        cyc(2);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(3);
        total += 6;
        if (pix_data !== 16'h0) begin bad++; $display("FAIL reset_pix_data: got %h, required 0", pix_data); end
        if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_pix_valid: got %b, required 0", pix_valid); end
        if (pix_addr !== 20'h0) begin bad++; $display("FAIL reset_pix_addr: got %h, required 0", pix_addr); end
        if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
        if (frame_cnt !== 16'h0) begin bad++; $display("FAIL reset_frame_cnt: got %h, required 0", frame_cnt); end
        if (err_odd !== 1'b0) begin bad++; $display("FAIL reset_err_odd: got %b, required 0", err_odd); end
        reset_n = 1'b1;
        cyc(3);
    endtask

    task automatic test_rgb565();
        int p0;
        p0 = n_pix;
        enable = 1'b1;
        fmt    = 1'b1;
        vsync_pulse();
        send_line(8, 8'h01, 8'h01);
        send_line(8, 8'h09, 8'h01);
        vsync_pulse();
        total += 5;
        if (n_pix - p0 !== 8) begin bad++; $display("FAIL rgb_count: got %0d, required 8", n_pix - p0); end
        if (sb.size() !== 0) begin bad++; $display("FAIL rgb_drain: got %0d left, required 0", sb.size()); end
        if (frame_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL rgb_frame_cnt: got %0d, required %0d", frame_cnt, exp_cnt); end
        if (n_done !== exp_done) begin bad++; $display("FAIL rgb_frame_done: got %0d, required %0d", n_done, exp_done); end
        if (err_odd !== 1'b0) begin bad++; $display("FAIL rgb_err_odd: got %b, required 0", err_odd); end
    endtask

    task automatic test_raw8();
        int p0;
        fmt = 1'b0;
        vsync_pulse();
        p0 = n_pix;
        send_line(3, 8'hAA, 8'h11);
        vsync_pulse();
        total += 4;
        if (n_pix - p0 !== 3) begin bad++; $display("FAIL raw_count: got %0d, required 3", n_pix - p0); end
        if (sb.size() !== 0) begin bad++; $display("FAIL raw_drain: got %0d left, required 0", sb.size()); end
        if (frame_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL raw_frame_cnt: got %0d, required %0d", frame_cnt, exp_cnt); end
        if (err_odd !== 1'b0) begin bad++; $display("FAIL raw_err_odd: got %b, required 0", err_odd); end
    endtask

    task automatic test_odd_byte();
        fmt = 1'b1;
        vsync_pulse();
        send_line(5, 8'h20, 8'h01);
        total++;
        if (err_odd !== b_err) begin bad++; $display("FAIL odd_err_set: got %b, required %b", err_odd, b_err); end
        send_line(4, 8'h30, 8'h01);
        vsync_pulse();
        total += 3;
        if (err_odd !== 1'b1) begin bad++; $display("FAIL odd_err_sticky: got %b, required 1", err_odd); end
        if (sb.size() !== 0) begin bad++; $display("FAIL odd_drain: got %0d left, required 0", sb.size()); end
        if (frame_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL odd_frame_cnt: got %0d, required %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_disabled();
        int p0;
        int c0;
        enable = 1'b0;
        vsync_pulse();
        c0 = exp_cnt;
        p0 = n_pix;
        send_line(4, 8'h40, 8'h01);
        vsync_pulse();
        send_line(4, 8'h44, 8'h01);
        total += 3;
        if (n_pix - p0 !== 0) begin bad++; $display("FAIL dis_count: got %0d, required 0", n_pix - p0); end
        if (frame_cnt !== 16'(c0)) begin bad++; $display("FAIL dis_frame_cnt: got %0d, required %0d", frame_cnt, c0); end
        if (n_done !== exp_done) begin bad++; $display("FAIL dis_frame_done: got %0d, required %0d", n_done, exp_done); end
        enable = 1'b1;
        vsync_pulse();
    endtask

    task automatic test_vsync_in_line();
        csi_hsync = 1'b1;
        csi_data  = 8'h11; cyc(1);
        csi_data  = 8'h22; push_pix(16'h1122, 0); cyc(1);
        csi_data  = 8'h33; cyc(1);
        // vsync rises while the second pixel is only half assembled
        csi_data  = 8'h44;
        csi_vsync = 1'b1;
        exp_cnt = (exp_cnt + 1) % 65536;
        exp_done++;
        b_active = enable; b_fmt = fmt; b_addr = 0; b_y = 0;
        cyc(1);
        csi_hsync = 1'b0;
        cyc(1);
        csi_vsync = 1'b0;
        cyc(2);
        send_line(4, 8'h50, 8'h01);
        vsync_pulse();
        total += 3;
        if (sb.size() !== 0) begin bad++; $display("FAIL vin_drain: got %0d left, required 0", sb.size()); end
        if (frame_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL vin_frame_cnt: got %0d, required %0d", frame_cnt, exp_cnt); end
        if (n_done !== exp_done) begin bad++; $display("FAIL vin_frame_done: got %0d, required %0d", n_done, exp_done); end
    endtask

    task automatic test_reset_midline();
        int p0;
        send_line(4, 8'h60, 8'h01);
        total += 2;
        if (pix_addr !== 20'd1) begin bad++; $display("FAIL rml_pre_addr: got %0d, required 1", pix_addr); end
        if (pix_data !== 16'h6263) begin bad++; $display("FAIL rml_pre_data: got %h, required 6263", pix_data); end
        csi_hsync = 1'b1;
        csi_data  = 8'h70;
        cyc(1);
        #2;
        reset_n = 1'b0;
        #1;
        total += 5;
        if (pix_addr !== 20'd0) begin bad++; $display("FAIL rml_addr: got %0d, required 0", pix_addr); end
        if (pix_data !== 16'h0) begin bad++; $display("FAIL rml_data: got %h, required 0", pix_data); end
        if (frame_cnt !== 16'h0) begin bad++; $display("FAIL rml_frame_cnt: got %0d, required 0", frame_cnt); end
        if (err_odd !== 1'b0) begin bad++; $display("FAIL rml_err_odd: got %b, required 0", err_odd); end
        if (pix_valid !== 1'b0) begin bad++; $display("FAIL rml_valid: got %b, required 0", pix_valid); end
        b_active = 0; b_err = 0; exp_cnt = 0; b_addr = 0; b_y = 0;
        p0 = n_pix;
        csi_data = 8'h71; cyc(1);
        csi_data = 8'h72; cyc(1);
        reset_n = 1'b1;
        csi_data = 8'h73; cyc(1);
        csi_data = 8'h74; cyc(1);
        csi_data = 8'h75; cyc(1);
        csi_hsync = 1'b0;
        cyc(2);
        send_line(4, 8'h76, 8'h01);
        total++;
        if (n_pix - p0 !== 0) begin bad++; $display("FAIL rml_idle_pix: got %0d, required 0", n_pix - p0); end
        vsync_pulse();
        send_line(4, 8'h80, 8'h01);
        vsync_pulse();
        total += 2;
        if (sb.size() !== 0) begin bad++; $display("FAIL rml_drain: got %0d left, required 0", sb.size()); end
        if (frame_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL rml_frame_cnt2: got %0d, required %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_crop();
        int p0;
        int exp_n;
`ifdef CAM_CAPTURE_CROP_EN
        exp_n = 6;
`else
        exp_n = 32;
`endif
        fmt     = 1'b0;
        crop_x0 = 12'd2;
        crop_y0 = 12'd1;
        crop_w  = 12'd3;
        crop_h  = 12'd2;
        vsync_pulse();
        p0 = n_pix;
        for (int y = 0; y < 4; y++) begin
            send_line(8, 8'(y * 16), 8'h01);
        end
        vsync_pulse();
        total += 3;
        if (n_pix - p0 !== exp_n) begin bad++; $display("FAIL crop_count: got %0d, required %0d", n_pix - p0, exp_n); end
        if (sb.size() !== 0) begin bad++; $display("FAIL crop_drain: got %0d left, required 0", sb.size()); end
        if (frame_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL crop_frame_cnt: got %0d, required %0d", frame_cnt, exp_cnt); end
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        fmt       = 1'b0;
        csi_data  = 8'h00;
        csi_vsync = 1'b0;
        csi_hsync = 1'b0;
        crop_x0   = '0;
        crop_y0   = '0;
        crop_w    = '0;
        crop_h    = '0;
        test_reset();
        test_rgb565();
        test_raw8();
        test_odd_byte();
        test_disabled();
        test_vsync_in_line();
        test_reset_midline();
        test_crop();
        cyc(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
